tgate_bus_arbiter: RTL
======================

// Module: tgate_bus_arbiter
// PURPOSE
//  Shares one transmission-gate switch bus between N requesters. Each requester
//  owns one tgate switch (nmos gate = sel[i], pmos gate = sel_n[i]).
//  Grants access round-robin. Enforces break-before-make dead time, so no two
//  switches ever conduct together, and a maximum hold time when others wait.
//  Sits between requester control logic and the tgate switch array.
// PARAMETERS
//  N            4   number of requesters; legal range 2..16
//  DEAD_CYCLES  2   all-switches-off cycles before any grant; legal range >= 1
//  MAX_HOLD     8   grant cycles before forced release if another req pending; >= 1
// PORTS
//  clk        in   1             rising-edge clock
//  rst        in   1             asynchronous, active-high reset
//  req        in   N             level request per requester; held until done
//  sel        out  N             one-hot nmos gate drive; 0 = all switches open
//  sel_n      out  N             pmos gate drive, always exactly ~sel
//  gnt_valid  out  1             1 while in GRANT (sel != 0)
//  gnt_idx    out  $clog2(N)     index of granted requester; valid only with gnt_valid
//  busy       out  1             1 when state != IDLE
// BEHAVIOUR
//  - Every output is registered.
//  - Reset values: sel=0, sel_n=all 1, gnt_valid=0, gnt_idx=0, busy=0, state=IDLE.
//  - Reset internals: last_idx=N-1 (req[0] wins first), dead_cnt=0, hold_cnt=0.
//  - Reset takes effect immediately at any point, including mid-grant: all switches open at once.
//  - States: IDLE, DEAD, GRANT.
//  - IDLE:  if |req at an edge -> DEAD, dead_cnt=0. Otherwise stay in IDLE.
//  - DEAD:  sel=0. dead_cnt increments each edge.
//           At the edge where dead_cnt==DEAD_CYCLES-1, arbitrate on the current req:
//             winner found -> GRANT: sel=onehot(winner), gnt_idx=winner,
//                             last_idx=winner, hold_cnt=1.
//             req==0       -> IDLE. A req that drops during DEAD is not granted.
//  - Latency: req high before edge E1 -> sel high after edge E1+DEAD_CYCLES.
//    DEAD_CYCLES=2 gives 3 edges.
//  - Arbitration: round-robin search starting at (last_idx+1) mod N and wrapping.
//    The previous winner is eligible only when no other req is set.
//  - GRANT: hold_cnt saturates at MAX_HOLD. At each edge the grant is released when either:
//      (a) req[gnt_idx]==0, or
//      (b) hold_cnt==MAX_HOLD and (req & ~onehot(gnt_idx)) != 0.
//    On release: next edge sel=0, gnt_valid=0, go to DEAD with dead_cnt=0.
//    Without a release condition the grant holds indefinitely, even past MAX_HOLD.
//  - Simultaneous events:
//      (a) and (b) true together -> one release only.
//      New reqs arriving in GRANT are only considered at DEAD exit.
//  - Invariants, checked every cycle:
//      $onehot0(sel); sel_n==~sel;
//      the sel transition between two different nonzero values passes through
//      >= DEAD_CYCLES cycles of sel==0.
// STRUCTURE
//  - Package tgate_arb_pkg:
//      state encoding localparams ST_IDLE=2'd0, ST_DEAD=2'd1, ST_GRANT=2'd2;
//      function onehot(idx, N).
//  - Sub-module rr_pick: combinational round-robin picker.
//      Inputs req[N], last_idx. Outputs found, idx.
//      Instanced once; the FSM and counters live in the top level.
// TESTING
//  1. Reset, then req=4'b0001 at E1.
//     -> sel=0001, gnt_idx=0 after E3 (DEAD_CYCLES=2); sel_n=1110.
//  2. req=4'b0101 held constantly.
//     -> grants alternate 0,2,0,2. Each grant lasts 8 cycles (MAX_HOLD).
//        Exactly 2 cycles of sel=0 between grants.
//  3. Only req[3] held for 50 cycles.
//     -> a single grant on sel=1000 for the whole time; no forced release.
//  4. req[1] pulsed high for 1 cycle only, dropping during DEAD.
//     -> no grant; state returns to IDLE; busy falls after the DEAD exit.
//  5. Grant active on idx 2, rst asserted mid-cycle.
//     -> sel=0, sel_n=1111 with no clock edge. After rst release, req=1111 grants idx 0 first.
//  6. Random req for 10k cycles.
//     -> $onehot0(sel), sel_n==~sel and the dead-time invariant hold throughout.
//        Every requester holding req high is granted within (N-1)*(MAX_HOLD+DEAD_CYCLES)+DEAD_CYCLES+1 cycles.

Source files
------------

// File: rtl/tgate_arb_pkg.sv
// Shared definitions for the transmission-gate bus arbiter: FSM state
// encoding and the one-hot decode used to drive the switch gates.
package tgate_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DEAD  = 2'd1;
  localparam logic [1:0] ST_GRANT = 2'd2;

  localparam int MAX_N = 16;

  // Callers truncate the result to their own requester count.
  function automatic logic [MAX_N-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [MAX_N-1:0] v;
    v = '0;
    if (idx < n && idx < MAX_N) v[idx[3:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after last_idx,
// wrapping, so the previous winner is only chosen when it is alone.
module rr_pick
  import tgate_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_idx,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last_idx) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/tgate_bus_arbiter.sv
// Round-robin owner of a shared tgate switch bus with break-before-make dead
// time and a hold limit that only bites while someone else is waiting.
module tgate_bus_arbiter
  import tgate_arb_pkg::*;
#(
  parameter int N           = 4,
  parameter int DEAD_CYCLES = 2,
  parameter int MAX_HOLD    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         sel,
  output logic [N-1:0]         sel_n,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 busy
);

  localparam int IW = $clog2(N);
  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [IW-1:0] last_idx;
  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic [DW-1:0] dead_cnt;
  logic [HW-1:0] hold_cnt;

  logic          dead_last;
  logic          hold_full;
  logic          rel_cond;
  logic          grant_now;
  logic          release_now;
  logic [N-1:0]  oh_win;
  logic [N-1:0]  oh_gnt;
  logic [N-1:0]  others;

  logic [N-1:0]  sel_d;
  logic          gnt_valid_d;
  logic [IW-1:0] gnt_idx_d;
  logic          busy_d;

  rr_pick #(.N(N)) u_pick (
    .req      (req),
    .last_idx (last_idx),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  assign oh_win    = N'(onehot(32'(pick_idx), N));
  assign oh_gnt    = N'(onehot(32'(gnt_idx), N));
  assign others    = req & ~oh_gnt;
  assign dead_last = (dead_cnt == DW'(DEAD_CYCLES - 1));
  assign hold_full = (hold_cnt == HW'(MAX_HOLD));
  // Owner dropping and forced release collapse into one release event.
  assign rel_cond  = !req[gnt_idx] || (hold_full && (|others));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    grant_now   = 1'b0;
    release_now = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|req) state_nxt = ST_DEAD;
      end
      ST_DEAD: begin
        // Arbitration sees req as it is now; a request gone by DEAD exit is dropped.
        if (dead_last) begin
          if (pick_found) begin
            state_nxt = ST_GRANT;
            grant_now = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_GRANT: begin
        if (rel_cond) begin
          state_nxt   = ST_DEAD;
          release_now = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_d       = '0;
    gnt_valid_d = 1'b0;
    gnt_idx_d   = gnt_idx;
    busy_d      = (state_nxt != ST_IDLE);
    if (grant_now) begin
      sel_d       = oh_win;
      gnt_valid_d = 1'b1;
      gnt_idx_d   = pick_idx;
    end else if (state_nxt == ST_GRANT) begin
      sel_d       = sel;
      gnt_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_idx <= IW'(N - 1);
      dead_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      if (release_now || (state == ST_IDLE && state_nxt == ST_DEAD)) dead_cnt <= '0;
      else if (state == ST_DEAD)                                   dead_cnt <= dead_cnt + DW'(1);

      if (grant_now) begin
        hold_cnt <= HW'(1);
        last_idx <= pick_idx;
      end else if (state == ST_GRANT && !release_now && !hold_full) begin
        hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end

  // Gate drives come straight from flops; reset opens every switch at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel       <= '0;
      sel_n     <= '1;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      busy      <= 1'b0;
    end else begin
      sel       <= sel_d;
      sel_n     <= ~sel_d;
      gnt_valid <= gnt_valid_d;
      gnt_idx   <= gnt_idx_d;
      busy      <= busy_d;
    end
  end

endmodule
